// File: rtl/axi_stream_pin_sink.sv
// AXI4-Stream slave: buffers {tlast,tdata} words in a small FIFO and serializes them LSB byte first
// onto an 8-bit valid/ready pin bus, while checking packet framing and tkeep.
module axi_stream_pin_sink #(
  parameter int FIFO_DEPTH_BITS  = 4,
  parameter int WORDS_PER_PACKET = 262144
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic [3:0]  s_axis_tkeep,
  input  logic [3:0]  s_axis_tstrb,
  input  logic [1:0]  s_axis_tdest,
  input  logic [7:0]  s_axis_tid,
  output logic [7:0]  data_pins,
  output logic        pins_valid,
  input  logic        pins_ready,
  output logic        pins_last,
  output logic        packet_done,
  output logic        err_tlast_early,
  output logic        err_tlast_missing,
  output logic        err_keep,
  input  logic        error_clear
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = $clog2(WORDS_PER_PACKET) + 1;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_PACKET - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [32:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  logic [0:0]                 state_q, state_d;
  logic [31:0]                shift_q, shift_d;
  logic                       last_q, last_d;
  logic [1:0]                 byte_idx_q, byte_idx_d;
  logic [CW-1:0]              wcnt_q, wcnt_d;
  logic                       early_q, early_d;
  logic                       missing_q, missing_d;
  logic                       keep_q, keep_d;
  logic                       done_q, done_d;

  logic accept;
  logic fifo_empty;
  logic byte_hs;
  logic load;
  logic set_early;
  logic set_missing;
  logic set_keep;
  logic unused_sidebands;

  assign unused_sidebands = ^{s_axis_tstrb, s_axis_tdest, s_axis_tid};

  // Ready depends on registered occupancy only, never on tvalid.
  assign s_axis_tready = !areset && (count_q != FULL_CNT);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign fifo_empty    = (count_q == '0);

  assign pins_valid  = (state_q == ST_SEND);
  assign data_pins   = pins_valid ? shift_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
  assign pins_last   = pins_valid && (byte_idx_q == 2'd3) && last_q;
  assign packet_done = done_q;

  assign err_tlast_early   = early_q;
  assign err_tlast_missing = missing_q;
  assign err_keep          = keep_q;

  assign byte_hs = pins_valid && pins_ready;
  // Reload on the final byte handshake so back-to-back words stream without a bubble.
  assign load    = !fifo_empty && ((state_q == ST_IDLE) || (byte_hs && (byte_idx_q == 2'd3)));

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({accept, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    last_d     = last_q;
    byte_idx_d = byte_idx_q;
    if (load) begin
      {last_d, shift_d} = mem_q[rd_ptr_q];
      byte_idx_d        = 2'd0;
      state_d           = ST_SEND;
    end else if (byte_hs) begin
      byte_idx_d = byte_idx_q + 1'b1;
      if (byte_idx_q == 2'd3) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    wcnt_d      = wcnt_q;
    set_early   = 1'b0;
    set_missing = 1'b0;
    set_keep    = accept && (s_axis_tkeep != 4'b1111);
    if (accept) begin
      if (wcnt_q == LAST_IDX) begin
        wcnt_d      = '0;
        set_missing = !s_axis_tlast;
      end else if (s_axis_tlast) begin
        wcnt_d    = '0;
        set_early = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    // A clear on the same edge as a new error wins.
    early_d   = error_clear ? 1'b0 : (early_q || set_early);
    missing_d = error_clear ? 1'b0 : (missing_q || set_missing);
    keep_d    = error_clear ? 1'b0 : (keep_q || set_keep);
    done_d    = byte_hs && pins_last;
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      last_q     <= 1'b0;
      byte_idx_q <= 2'd0;
      wcnt_q     <= '0;
      early_q    <= 1'b0;
      missing_q  <= 1'b0;
      keep_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      byte_idx_q <= byte_idx_d;
      wcnt_q     <= wcnt_d;
      early_q    <= early_d;
      missing_q  <= missing_d;
      keep_q     <= keep_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_pin_sink.sv
// Bench for axi_stream_pin_sink: directed scenarios plus a randomized phase, checked by a byte
// scoreboard and a packet-level framing model fed from observed stream handshakes.
module tb_axi_stream_pin_sink;
  localparam int WPP = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic [3:0]  s_axis_tkeep = 4'hF;
  logic [3:0]  s_axis_tstrb = 4'hF;
  logic [1:0]  s_axis_tdest = '0;
  logic [7:0]  s_axis_tid = '0;
  logic [7:0]  data_pins;
  logic        pins_valid;
  logic        pins_ready = 1'b0;
  logic        pins_last;
  logic        packet_done;
  logic        err_tlast_early;
  logic        err_tlast_missing;
  logic        err_keep;
  logic        error_clear = 1'b0;

  axi_stream_pin_sink #(.FIFO_DEPTH_BITS(4), .WORDS_PER_PACKET(WPP)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tdest(s_axis_tdest), .s_axis_tid(s_axis_tid),
    .data_pins(data_pins), .pins_valid(pins_valid), .pins_ready(pins_ready),
    .pins_last(pins_last), .packet_done(packet_done),
    .err_tlast_early(err_tlast_early), .err_tlast_missing(err_tlast_missing),
    .err_keep(err_keep), .error_clear(error_clear)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [8:0] exp_q[$];
  int         hs_cyc[$];
  int         acc_cyc[$];
  int         pkt_words = 0;
  bit         m_early = 0, m_missing = 0, m_keep = 0, exp_pd = 0;
  bit         stall_hold = 0;
  logic [8:0] held;
  int         cyc = 0, acc_cnt = 0, pd_cnt = 0;
  bit         rnd_mode = 0;

  // Inputs change only at posedge+1, so values seen here are those the next edge will sample.
  always @(negedge aclk) begin
    logic [8:0] b;
    bit         pd_next;
    int         pos;
    cyc++;
    if (areset) begin
      exp_q.delete();
      pkt_words = 0;
      m_early = 0; m_missing = 0; m_keep = 0; exp_pd = 0; stall_hold = 0;
      chk("rst_outputs", {s_axis_tready, pins_valid, pins_last, packet_done, data_pins}, 64'h0);
      chk("rst_flags", {err_tlast_early, err_tlast_missing, err_keep}, 64'h0);
    end else begin
      chk("flags", {err_tlast_early, err_tlast_missing, err_keep}, {m_early, m_missing, m_keep});
      chk("packet_done", packet_done, exp_pd);
      if (packet_done) pd_cnt++;
      if (stall_hold) chk("stall_hold", {pins_valid, pins_last, data_pins}, {1'b1, held});
      pd_next = 0;
      if (pins_valid && pins_ready) begin
        hs_cyc.push_back(cyc);
        pd_next = pins_last;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL byte_unexpected: got %0h with nothing expected", data_pins);
        end else begin
          b = exp_q.pop_front();
          chk("byte", {pins_last, data_pins}, b);
        end
      end
      stall_hold = pins_valid && !pins_ready;
      held = {pins_last, data_pins};
      if (s_axis_tvalid && s_axis_tready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        for (int k = 0; k < 4; k++)
          exp_q.push_back({((k == 3) && s_axis_tlast), s_axis_tdata[8*k +: 8]});
        pos = pkt_words + 1;
        if (s_axis_tlast) begin
          if (pos < WPP) m_early = 1;
          pkt_words = 0;
        end else if (pos == WPP) begin
          m_missing = 1;
          pkt_words = 0;
        end else begin
          pkt_words = pos;
        end
        if (s_axis_tkeep != 4'hF) m_keep = 1;
      end
      if (error_clear) begin
        m_early = 0; m_missing = 0; m_keep = 0;
      end
      exp_pd = pd_next;
    end
  end

  always @(posedge aclk) begin
    #1;
    if (rnd_mode) begin
      pins_ready  = ($urandom_range(0, 1) == 1);
      error_clear = ($urandom_range(0, 9) == 0);
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, input logic [3:0] k);
    logic hs;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_axis_tkeep = k;
    s_axis_tid = 8'($urandom); s_axis_tdest = 2'($urandom);
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !pins_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 1, 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("rst_async", {s_axis_tready, pins_valid, pins_last, packet_done, data_pins}, 64'h0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic clear_trace();
    hs_cyc.delete();
    acc_cyc.delete();
    pd_cnt = 0;
  endtask

  initial begin
    int base;
    bit found;
    // Test 1: single word with tlast
    do_reset();
    pins_ready = 1'b1;
    clear_trace();
    send_word(32'h44332211, 1'b1, 4'hF);
    wait_drain();
    chk("t1_bytes", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4 && acc_cyc.size() == 1) begin
      chk("t1_latency", hs_cyc[0] - acc_cyc[0], 2);
      chk("t1_contig", hs_cyc[3] - hs_cyc[0], 3);
    end
    chk("t1_pd_count", pd_cnt, 1);
    chk("t1_early", err_tlast_early, 1);

    // Test 2: well-formed 4-word packet, no gaps
    error_clear = 1'b1;
    @(posedge aclk); #1 error_clear = 1'b0;
    clear_trace();
    for (int i = 0; i < 4; i++) send_word(32'h03020100 + 32'h04040404 * i, i == 3, 4'hF);
    wait_drain();
    chk("t2_bytes", hs_cyc.size(), 16);
    if (hs_cyc.size() == 16) chk("t2_nogap", hs_cyc[15] - hs_cyc[0], 15);
    chk("t2_flags", {err_tlast_early, err_tlast_missing, err_keep}, 0);
    chk("t2_pd_count", pd_cnt, 1);

    // Test 3: stalled pins, FIFO fills
    pins_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 17; i++) send_word(32'h100 + i, 1'b0, 4'hF);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h111; s_axis_tlast = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t3_tready_low", s_axis_tready, 0);
    chk("t3_accepted", acc_cnt - base, 17);
    pins_ready = 1'b1;
    send_word(32'h111, 1'b0, 4'hF);
    wait_drain();
    chk("t3_total", acc_cnt - base, 18);

    // Test 4: missing then early tlast, then clear
    do_reset();
    for (int i = 0; i < 4; i++) send_word(32'hA0 + i, 1'b0, 4'hF);
    chk("t4_missing", {err_tlast_missing, err_tlast_early}, 2'b10);
    send_word(32'hA4, 1'b1, 4'hF);
    chk("t4_early", {err_tlast_missing, err_tlast_early}, 2'b11);
    error_clear = 1'b1;
    @(posedge aclk); #1 error_clear = 1'b0;
    chk("t4_cleared", {err_tlast_missing, err_tlast_early}, 2'b00);
    wait_drain();

    // Test 5: partial tkeep still forwards all bytes
    clear_trace();
    send_word(32'hDEADBEEF, 1'b0, 4'b0111);
    chk("t5_keep", err_keep, 1);
    wait_drain();
    chk("t5_bytes", hs_cyc.size(), 4);

    // Test 6: reset mid-word, then a clean packet
    send_word(32'hA3A2A1A0, 1'b0, 4'hF);
    send_word(32'hB3B2B1B0, 1'b0, 4'hF);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge aclk);
      if (pins_valid && data_pins == 8'hA2) found = 1;
    end
    chk("t6_saw_byte2", found, 1);
    #1 areset = 1'b1;
    #1;
    chk("t6_rst_outputs", {s_axis_tready, pins_valid, pins_last, packet_done, data_pins}, 64'h0);
    chk("t6_rst_flags", {err_tlast_early, err_tlast_missing, err_keep}, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    clear_trace();
    for (int i = 0; i < 4; i++) send_word(32'hC3C2C1C0 + 32'h10101010 * i, i == 3, 4'hF);
    wait_drain();
    chk("t6_bytes", hs_cyc.size(), 16);
    chk("t6_flags", {err_tlast_early, err_tlast_missing, err_keep}, 0);
    chk("t6_pd_count", pd_cnt, 1);

    // Randomized phase
    rnd_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send_word($urandom, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 7) == 0) ? 4'b0111 : 4'hF);
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    end
    rnd_mode = 0;
    @(posedge aclk);
    #2 pins_ready = 1'b1; error_clear = 1'b0;
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
